// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise pipeline: operation encoding and the
// single-bit evaluation rule used to build the full-width result.
package bitwise_pkg;

  typedef enum logic [2:0] {
    BW_NOT  = 3'b000,
    BW_AND  = 3'b001,
    BW_OR   = 3'b010,
    BW_XOR  = 3'b011,
    BW_NAND = 3'b100,
    BW_NOR  = 3'b101,
    BW_XNOR = 3'b110,
    BW_PASS = 3'b111
  } bw_op_e;

  // Operands are independent per bit, so the rule is expressed on one bit
  // and replicated across the operand width by the caller.
  function automatic logic bw_eval(input bw_op_e op, input logic a, input logic b);
    case (op)
      BW_NOT:  bw_eval = ~a;
      BW_AND:  bw_eval = a & b;
      BW_OR:   bw_eval = a | b;
      BW_XOR:  bw_eval = a ^ b;
      BW_NAND: bw_eval = ~(a & b);
      BW_NOR:  bw_eval = ~(a | b);
      BW_XNOR: bw_eval = ~(a ^ b);
      default: bw_eval = a;
    endcase
  endfunction

endpackage

// File: rtl/bitwise_pipe_unit_slice.sv
// One register slice of an elastic pipeline: holds a valid bit and data word,
// accepts when empty or when the downstream slice is draining this cycle.
module pipe_slice
  import bitwise_pkg::*;
#(
  parameter int nb_bits_g = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 prev_valid,
  input  logic [nb_bits_g-1:0] prev_data,
  input  logic                 next_ready,
  output logic                 ready,
  output logic                 valid,
  output logic [nb_bits_g-1:0] data
);

  assign ready = ~valid | next_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= prev_valid;
      // Bubbles leave the held word untouched.
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/bitwise_pipe_unit.sv
// Pipelined bitwise logic unit: combinational op decode feeding a chain of
// nb_stages_g elastic register slices with valid/ready on both ends.
module bitwise_pipe_unit
  import bitwise_pkg::*;
#(
  parameter int delay       = 0,
  parameter int nb_bits_g   = 32,
  parameter int nb_stages_g = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [2:0]           op_i,
  input  logic [nb_bits_g-1:0] a_i,
  input  logic [nb_bits_g-1:0] b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [nb_bits_g-1:0] s_o,
  output logic                 zero_o,
  output logic                 busy_o
);

  if (nb_stages_g < 1 || nb_bits_g < 1 || delay < 0) begin : g_param_check
    $error("bitwise_pipe_unit: nb_stages_g and nb_bits_g must be >= 1, delay >= 0");
  end

  logic [nb_bits_g-1:0] result;
  logic [nb_stages_g:0] rdy;
  logic [nb_stages_g:0] vld;
  logic [nb_bits_g-1:0] data [nb_stages_g+1];

  always_comb begin
    result = '0;
    for (int i = 0; i < nb_bits_g; i++) begin
      result[i] = bw_eval(bw_op_e'(op_i), a_i[i], b_i[i]);
    end
  end

  assign vld[0]           = valid_i;
  assign data[0]          = result;
  assign rdy[nb_stages_g] = ready_i;

  // Stage boundaries: slice k sits between vld/data[k] and vld/data[k+1].
  for (genvar k = 0; k < nb_stages_g; k++) begin : g_slice
    pipe_slice #(
      .nb_bits_g(nb_bits_g)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .prev_valid(vld[k]),
      .prev_data (data[k]),
      .next_ready(rdy[k+1]),
      .ready     (rdy[k]),
      .valid     (vld[k+1]),
      .data      (data[k+1])
    );
  end

  assign ready_o = rdy[0] & ~rst_i;
  assign valid_o = vld[nb_stages_g];
  assign s_o     = data[nb_stages_g];
  assign zero_o  = valid_o & (s_o == '0);
  assign busy_o  = |vld[nb_stages_g:1];

endmodule

// File: tb/tb_bitwise_pipe_unit.sv
// Bench for bitwise_pipe_unit (8-bit, 2 stages): table vectors, handshake
// corner sequences and randomized traffic against a truth-table queue model.
module tb_bitwise_pipe_unit;

  localparam int W = 8;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [2:0]   op_i = 3'd0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] s_o;
  logic         zero_o;
  logic         busy_o;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] model_q[$];

  always #5 clk = ~clk;

  bitwise_pipe_unit #(
    .delay(0),
    .nb_bits_g(W),
    .nb_stages_g(N)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .s_o    (s_o),
    .zero_o (zero_o),
    .busy_o (busy_o)
  );

  // Each op is a 2-input truth table indexed by {a,b}.
  function automatic logic [W-1:0] ref_eval(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [3:0] tt [8];
    logic [3:0] t;
    logic [W-1:0] r;
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1100;
    t = tt[op];
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    valid_i = v; op_i = op; a_i = a; b_i = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: occupancy = accepted-but-not-emitted items.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_i) begin
        check("mon_rst_ready", ready_o, 0);
        model_q.delete();
      end else begin
        check("mon_ready", ready_o, !(model_q.size() == N && !ready_i));
        check("mon_busy", busy_o, model_q.size() != 0);
        check("mon_zero", zero_o, valid_o && (s_o == 0));
        if (valid_o && ready_i) begin
          check("mon_no_spurious", model_q.size() != 0, 1);
          if (model_q.size() != 0) check("mon_data", s_o, model_q.pop_front());
        end
        if (valid_i && ready_o) model_q.push_back(ref_eval(op_i, a_i, b_i));
      end
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tv[10];
  vec_t bp[3];

  initial begin
    logic [W-1:0] hold;
    logic [W-1:0] got[$];
    int idx;
    bit acc;

    tv[0] = '{3'b000, 8'hA5, 8'h00, 8'h5A};
    tv[1] = '{3'b000, 8'hCC, 8'hAA, 8'h33};
    tv[2] = '{3'b001, 8'hCC, 8'hAA, 8'h88};
    tv[3] = '{3'b010, 8'hCC, 8'hAA, 8'hEE};
    tv[4] = '{3'b011, 8'hCC, 8'hAA, 8'h66};
    tv[5] = '{3'b100, 8'hCC, 8'hAA, 8'h77};
    tv[6] = '{3'b101, 8'hCC, 8'hAA, 8'h11};
    tv[7] = '{3'b110, 8'hCC, 8'hAA, 8'h99};
    tv[8] = '{3'b111, 8'hCC, 8'hAA, 8'hCC};
    tv[9] = '{3'b011, 8'h3C, 8'h3C, 8'h00};

    bp[0] = '{3'b011, 8'h0F, 8'hF0, 8'hFF};
    bp[1] = '{3'b001, 8'hF0, 8'h3C, 8'h30};
    bp[2] = '{3'b101, 8'h01, 8'h02, 8'hFC};

    // Reset held two cycles with valid_i asserted.
    rst_i = 1'b1; ready_i = 1'b1;
    drive(1'b1, 3'b000, 8'hA5, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid_o", valid_o, 0);
    check("rst_s_o", s_o, 0);
    check("rst_ready_o", ready_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_zero_o", zero_o, 0);
    next_cycle();
    rst_i = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready_o", ready_o, 1);
    check("post_rst_busy_o", busy_o, 0);
    next_cycle();

    // Back-to-back table vectors; result i visible exactly N cycles after presentation.
    for (int c = 0; c < 10 + N; c++) begin
      if (c < 10) drive(1'b1, tv[c].op, tv[c].a, tv[c].b);
      else drive(1'b0, 3'b000, 8'h00, 8'h00);
      @(negedge clk);
      if (c < N) begin
        check("tbl_latency_valid_low", valid_o, 0);
      end else begin
        check("tbl_valid_o", valid_o, 1);
        check("tbl_s_o", s_o, tv[c-N].exp);
        check("tbl_zero_o", zero_o, tv[c-N].exp == 0);
      end
      next_cycle();
    end
    @(negedge clk);
    check("tbl_drained_valid", valid_o, 0);
    check("tbl_drained_zero", zero_o, 0);
    next_cycle();

    // Backpressure: with ready_i low only N items fit.
    ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, bp[idx].op, bp[idx].a, bp[idx].b);
      @(negedge clk);
      acc = ready_o;
      next_cycle();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    @(negedge clk);
    check("bp_ready_low", ready_o, 0);
    check("bp_valid_o", valid_o, 1);
    check("bp_head", s_o, bp[0].exp);
    hold = s_o;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check("bp_stable_s", s_o, hold);
      check("bp_stable_valid", valid_o, 1);
    end
    next_cycle();
    ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (idx < 3) drive(1'b1, bp[idx].op, bp[idx].a, bp[idx].b);
      else drive(1'b0, 3'b000, 8'h00, 8'h00);
      @(negedge clk);
      if (valid_o && ready_i) got.push_back(s_o);
      acc = valid_i && ready_o;
      next_cycle();
      if (acc) idx++;
    end
    check("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check("bp_order", got[i], bp[i].exp);
      else check("bp_missing", i, got.size());
    end

    // Reset pulse with two items in flight.
    drive(1'b1, 3'b001, 8'hFF, 8'h0F);
    next_cycle();
    drive(1'b1, 3'b010, 8'h10, 8'h01);
    next_cycle();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    rst_i = 1'b1;
    @(negedge clk);
    check("pulse_ready_low", ready_o, 0);
    next_cycle();
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("pulse_flushed_valid", valid_o, 0);
      check("pulse_ready_high", ready_o, 1);
      next_cycle();
    end
    drive(1'b1, 3'b100, 8'hF0, 8'hFF);
    @(negedge clk);
    check("pulse_after_accept", ready_o, 1);
    next_cycle();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    check("pulse_early_valid", valid_o, 0);
    next_cycle();
    @(negedge clk);
    check("pulse_late_valid", valid_o, 1);
    check("pulse_late_s", s_o, 8'h0F);
    next_cycle();

    // Randomized traffic with occasional resets; the scoreboard does the checking.
    for (int c = 0; c < 600; c++) begin
      rst_i   = ($urandom_range(0, 79) == 0);
      ready_i = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1) == 1, 3'($urandom), 8'($urandom), 8'($urandom));
      next_cycle();
    end
    rst_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    for (int c = 0; c < 20 && model_q.size() != 0; c++) next_cycle();
    @(negedge clk);
    check("rand_drained", model_q.size(), 0);
    check("rand_idle_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
